// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned COUNT_W    = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BCNT_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  // Byte address of word idx: base + 4*idx, 32-bit unsigned.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]  base,
                                                  input logic [COUNT_W-1:0] idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_word_assembler.sv
// 8->32 MSB-first word assembler. Only the first three bytes are stored;
// word_out presents them together with the byte currently on byte_in, so the
// complete word is available in the same cycle the fourth byte transfers.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_full
);

  localparam int unsigned HELD_W = WORD_W - BYTE_W;

  logic [HELD_W-1:0] r_held;
  logic [BCNT_W-1:0] r_byte_cnt;

  // Shift held bytes MSB-first; byte counter wraps 3 -> 0 at each word boundary.
  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      r_held     <= '0;
      r_byte_cnt <= '0;
    end else if (shift_en) begin
      r_held     <= {r_held[HELD_W-BYTE_W-1:0], byte_in};
      r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
    end
  end

  assign word_out  = {r_held, byte_in};
  assign word_full = shift_en && (r_byte_cnt == BCNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Programs instruction memory from a byte stream (16-bit BE word count, then
// 32-bit BE words) and holds the CPU in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              i_start,
  imem_loader_if.slave      i_bs,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_resetN
);

  localparam int unsigned MAX_WORDS = MEM_SIZE / WORD_BYTES;

  loader_state_t      r_state;
  logic               r_in_ready;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0]  r_mem_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_cpu_resetN;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_word_idx;

  logic               w_xfer;
  logic               w_start_ok;
  logic               w_shift;
  logic               w_word_full;
  logic               w_last_word;
  logic               w_hdr_over;
  logic [WORD_W-1:0]  w_word;
  logic [COUNT_W-1:0] w_hdr_count;

  assign w_xfer      = i_bs.in_valid && r_in_ready;
  assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_shift     = w_xfer && (r_state == DATA);
  assign w_hdr_count = {r_count[COUNT_W-1:BYTE_W], i_bs.in_data};
  assign w_hdr_over  = 32'(w_hdr_count) > 32'(MAX_WORDS);
  assign w_last_word = (r_word_idx + COUNT_W'(1)) == r_count;

  imem_loader_word_assembler u_asm (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (w_start_ok),
    .shift_en  (w_shift),
    .byte_in   (i_bs.in_data),
    .word_out  (w_word),
    .word_full (w_word_full)
  );

  // Loader FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_resetN <= 1'b0;
      r_count      <= '0;
      r_word_idx   <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            r_state      <= HDR_HI;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_resetN <= 1'b0;
            r_count      <= '0;
            r_word_idx   <= '0;
          end
        end
        HDR_HI: begin
          if (w_xfer) begin
            r_count[COUNT_W-1:BYTE_W] <= i_bs.in_data;
            r_state                   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_xfer) begin
            r_count[BYTE_W-1:0] <= i_bs.in_data;
            if (w_hdr_count == '0) begin
              r_state      <= DONE;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_cpu_resetN <= 1'b1;
            end else if (w_hdr_over) begin
              r_state    <= ERROR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_word_full) begin
            r_state     <= WRITE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= word_addr(ADDR_W'(BASE_ADDR), r_word_idx);
            r_mem_wdata <= w_word;
          end
        end
        WRITE: begin
          if (w_last_word) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_cpu_resetN <= 1'b1;
          end else begin
            r_state    <= DATA;
            r_in_ready <= 1'b1;
            r_word_idx <= r_word_idx + COUNT_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign i_bs.in_ready = r_in_ready;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_cpu_resetN  = r_cpu_resetN;

endmodule
